// File: rtl/image_proc_ctrl_pkg.sv
// Shared types and constants for the image_proc_ctrl frame sequencer.
package image_proc_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int COORD_W     = 11;
    localparam int PIX_CNT_W   = 20;
    localparam int FRAME_CNT_W = 16;

    localparam int DEF_IMG_W   = 640;
    localparam int DEF_IMG_H   = 480;

endpackage

// File: rtl/image_proc_ctrl_sync_ff.sv
// Multi-stage flop synchronizer for a single asynchronous bit; clears to 0 on reset.
module sync_ff #(
    parameter int unsigned DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_chain;

    // Shift the raw input through DEPTH flops
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[DEPTH-2:0], i_d};
        end
    end

    assign o_q = r_chain[DEPTH-1];

endmodule

// File: rtl/image_proc_ctrl.sv
// Frame-level sequencer in front of the greyscale/convolution/abs pipeline.
// Gates pixel-valid on frame boundaries, freezes the filter direction per
// frame, drains the pipeline latency and reports frame completion.
// Optional feature macro: IMG_PROC_CTRL_STATS_EN (adds oLastPixCnt).
module image_proc_ctrl
    import image_proc_pkg::*;
#(
    parameter int unsigned IMG_W       = DEF_IMG_W,
    parameter int unsigned IMG_H       = DEF_IMG_H,
    parameter int unsigned PIPE_LAT    = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic                   iEnable,
    input  logic                   iSwitch,
    input  logic [COORD_W-1:0]     iX_Cont,
    input  logic [COORD_W-1:0]     iY_Cont,
    input  logic                   iDVAL,
    output logic                   oDVAL,
    output logic                   oMode,
    output logic                   oBusy,
    output logic                   oFrameStart,
    output logic                   oFrameDone,
    output logic [FRAME_CNT_W-1:0] oFrameCnt,
    output logic                   oErr
`ifdef IMG_PROC_CTRL_STATS_EN
    ,
    output logic [PIX_CNT_W-1:0]   oLastPixCnt
`endif
);

    localparam int unsigned DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [PIX_CNT_W-1:0] FRAME_PIX  = PIX_CNT_W'(IMG_W * IMG_H);
    localparam logic [PIX_CNT_W-1:0] ONE_PIX    = PIX_CNT_W'(1);
    localparam logic [COORD_W-1:0]   LAST_X     = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0]   LAST_Y     = COORD_W'(IMG_H - 1);
    localparam logic [DRAIN_W-1:0]   LAST_DRAIN = DRAIN_W'(PIPE_LAT - 1);

    state_t                   r_state;
    logic [PIX_CNT_W-1:0]     r_pix_cnt;
    logic [DRAIN_W-1:0]       r_drain_cnt;
    logic                     r_mode;
    logic                     r_start;
    logic                     r_done;
    logic [FRAME_CNT_W-1:0]   r_frame_cnt;
    logic                     r_err;
`ifdef IMG_PROC_CTRL_STATS_EN
    logic [PIX_CNT_W-1:0]     r_last_pix;
`else
    // no per-frame pixel statistics register in this build
`endif

    logic                     w_sw_s;
    logic                     w_sof;
    logic                     w_eof;
    logic [PIX_CNT_W-1:0]     w_pix_inc;

    sync_ff #(
        .DEPTH (SYNC_STAGES)
    ) u_sw_sync (
        .i_clk   (iCLK),
        .i_rst_n (iRST),
        .i_d     (iSwitch),
        .o_q     (w_sw_s)
    );

    assign w_sof     = iDVAL && (iX_Cont == '0) && (iY_Cont == '0);
    assign w_eof     = iDVAL && (iX_Cont == LAST_X) && (iY_Cont == LAST_Y);
    assign w_pix_inc = r_pix_cnt + 1'b1;

    // Zero-latency pixel-valid gate; the first pixel of a frame passes straight from ARMED
    always_comb begin
        oDVAL = 1'b0;
        case (r_state)
            ARMED:   oDVAL = w_sof;
            RUN:     oDVAL = iDVAL;
            default: oDVAL = 1'b0;
        endcase
    end

    // Frame sequencer with registered mode, pulses, counters and sticky error
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_state     <= IDLE;
            r_pix_cnt   <= '0;
            r_drain_cnt <= '0;
            r_mode      <= 1'b0;
            r_start     <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
            r_err       <= 1'b0;
`ifdef IMG_PROC_CTRL_STATS_EN
            r_last_pix  <= '0;
`endif
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (iEnable) begin
                        r_state <= ARMED;
                        r_mode  <= w_sw_s;
                    end
                end
                ARMED: begin
                    if (!iEnable) begin
                        r_state <= IDLE;
                    end else if (w_sof) begin
                        r_start   <= 1'b1;
                        r_pix_cnt <= ONE_PIX;
                        // A 1x1 frame's only pixel is also its EOF
                        if (w_eof) begin
                            r_state     <= DRAIN;
                            r_drain_cnt <= '0;
                            if (FRAME_PIX != ONE_PIX) begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (iDVAL) begin
                        if (w_eof) begin
                            r_state     <= DRAIN;
                            r_drain_cnt <= '0;
                            r_pix_cnt   <= w_pix_inc;
                            if (w_pix_inc != FRAME_PIX) begin
                                r_err <= 1'b1;
                            end
                        end else if (w_sof) begin
                            r_err     <= 1'b1;
                            r_pix_cnt <= ONE_PIX;
                            r_start   <= 1'b1;
                        end else begin
                            r_pix_cnt <= w_pix_inc;
                        end
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == LAST_DRAIN) begin
                        r_done      <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 1'b1;
`ifdef IMG_PROC_CTRL_STATS_EN
                        r_last_pix  <= r_pix_cnt;
`endif
                        if (iEnable) begin
                            r_state <= ARMED;
                            r_mode  <= w_sw_s;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign oMode       = r_mode;
    assign oBusy       = (r_state == RUN) || (r_state == DRAIN);
    assign oFrameStart = r_start;
    assign oFrameDone  = r_done;
    assign oFrameCnt   = r_frame_cnt;
    assign oErr        = r_err;
`ifdef IMG_PROC_CTRL_STATS_EN
    assign oLastPixCnt = r_last_pix;
`endif

endmodule

// File: tb/tb_image_proc_ctrl.sv
// Directed/randomized bench for image_proc_ctrl on a 4x2 image with PIPE_LAT=3.
module tb_image_proc_ctrl;
    import image_proc_pkg::*;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int LAT  = 3;
    localparam int NPIX = W * H;

    logic                   iCLK = 1'b0;
    logic                   iRST;
    logic                   iEnable;
    logic                   iSwitch;
    logic [COORD_W-1:0]     iX_Cont;
    logic [COORD_W-1:0]     iY_Cont;
    logic                   iDVAL;
    logic                   oDVAL;
    logic                   oMode;
    logic                   oBusy;
    logic                   oFrameStart;
    logic                   oFrameDone;
    logic [FRAME_CNT_W-1:0] oFrameCnt;
    logic                   oErr;
`ifdef IMG_PROC_CTRL_STATS_EN
    logic [PIX_CNT_W-1:0]   oLastPixCnt;
`endif

    image_proc_ctrl #(
        .IMG_W       (W),
        .IMG_H       (H),
        .PIPE_LAT    (LAT),
        .SYNC_STAGES (2)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iEnable     (iEnable),
        .iSwitch     (iSwitch),
        .iX_Cont     (iX_Cont),
        .iY_Cont     (iY_Cont),
        .iDVAL       (iDVAL),
        .oDVAL       (oDVAL),
        .oMode       (oMode),
        .oBusy       (oBusy),
        .oFrameStart (oFrameStart),
        .oFrameDone  (oFrameDone),
        .oFrameCnt   (oFrameCnt),
        .oErr        (oErr)
`ifdef IMG_PROC_CTRL_STATS_EN
        ,
        .oLastPixCnt (oLastPixCnt)
`endif
    );

    always #5 iCLK = ~iCLK;

    int checks   = 0;
    int failures = 0;

    // Frame-level reference: completed frames, sticky error, frozen mode
    logic [15:0] exp_cnt  = '0;
    logic        exp_err  = 1'b0;
    logic        exp_mode = 1'b0;
    logic        sw_a;
    logic        sw_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dval"},  32'(oDVAL),       0);
        chk({tag, "_mode"},  32'(oMode),       0);
        chk({tag, "_busy"},  32'(oBusy),       0);
        chk({tag, "_start"}, 32'(oFrameStart), 0);
        chk({tag, "_done"},  32'(oFrameDone),  0);
        chk({tag, "_cnt"},   32'(oFrameCnt),   0);
        chk({tag, "_err"},   32'(oErr),        0);
    endtask

    // One pixel at raster index p; oDVAL is checked combinationally before the edge
    task automatic pix(input int p, input logic pass);
        iDVAL   = 1'b1;
        iX_Cont = COORD_W'(p % W);
        iY_Cont = COORD_W'(p / W);
        #1;
        chk("dval_pix", 32'(oDVAL), 32'(pass));
        tick();
        iDVAL = 1'b0;
    endtask

    // Raster pixels first..last with random valid-low bubbles between them
    task automatic frame_pixels(input int first, input int last, input logic pass);
        for (int p = first; p <= last; p++) begin
            if (p != first) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    iDVAL   = 1'b0;
                    iX_Cont = COORD_W'($urandom_range(0, 7));
                    iY_Cont = COORD_W'($urandom_range(0, 3));
                    #1;
                    chk("dval_gap", 32'(oDVAL), 0);
                    tick();
                end
            end
            pix(p, pass);
            if (p == first && first == 0) begin
                chk("start", 32'(oFrameStart), 32'(pass));
                chk("busy_run", 32'(oBusy), 32'(pass));
                chk("err_sof", 32'(oErr), 32'(exp_err));
            end else begin
                chk("start_mid", 32'(oFrameStart), 0);
            end
            chk("mode_run", 32'(oMode), 32'(exp_mode));
        end
    endtask

    // Follows the EOF edge: expects LAT drain cycles, then the done pulse and count
    task automatic drain(input logic sof_probe, input int seg_pix);
        for (int i = 0; i < LAT; i++) begin
            if (i == 0 && sof_probe) begin
                iDVAL   = 1'b1;
                iX_Cont = '0;
                iY_Cont = '0;
                #1;
                chk("dval_drain_sof", 32'(oDVAL), 0);
            end
            chk("busy_drain", 32'(oBusy), 1);
            chk("mode_drain", 32'(oMode), 32'(exp_mode));
            chk("cnt_drain", 32'(oFrameCnt), 32'(exp_cnt));
            tick();
            iDVAL = 1'b0;
            chk("done", 32'(oFrameDone), (i == LAT - 1) ? 1 : 0);
        end
        exp_cnt = exp_cnt + 16'd1;
        chk("cnt", 32'(oFrameCnt), 32'(exp_cnt));
        chk("err", 32'(oErr), 32'(exp_err));
`ifdef IMG_PROC_CTRL_STATS_EN
        chk("lastpix", 32'(oLastPixCnt), 32'(seg_pix));
`else
        if (seg_pix < 0) $display("negative segment length %0d", seg_pix);
`endif
        if (iEnable) exp_mode = iSwitch;
    endtask

    initial begin
        // Reset with a SOF pixel presented: everything stays 0
        iRST = 1'b0; iEnable = 1'b0; iSwitch = 1'b1;
        iDVAL = 1'b1; iX_Cont = '0; iY_Cont = '0;
        tick(); tick();
        chk_all_zero("rst");
        iDVAL = 1'b0; iRST = 1'b1;
        tick(); tick(); tick();
        chk("idle_mode", 32'(oMode), 0);
        chk("idle_busy", 32'(oBusy), 0);

        // Plain 4x2 frame with iSwitch=1 held
        iEnable = 1'b1;
        tick();
        exp_mode = 1'b1;
        chk("armed_mode", 32'(oMode), 32'(exp_mode));
        chk("armed_busy", 32'(oBusy), 0);
        frame_pixels(0, NPIX - 1, 1'b1);
        drain(1'b0, NPIX);
        tick();
        chk("done_clear", 32'(oFrameDone), 0);
        chk("busy_rearm", 32'(oBusy), 0);

        // Switch changes mid-frame; mode follows only after DRAIN exits
        sw_a = 1'($urandom_range(0, 1));
        sw_b = ~sw_a;
        iEnable = 1'b0;
        tick();
        iSwitch = sw_a;
        tick(); tick(); tick();
        iEnable = 1'b1;
        tick();
        exp_mode = sw_a;
        chk("mode_a", 32'(oMode), 32'(exp_mode));
        frame_pixels(0, 2, 1'b1);
        iSwitch = sw_b;
        frame_pixels(3, NPIX - 1, 1'b1);
        drain(1'b0, NPIX);
        chk("mode_b", 32'(oMode), 32'(sw_b));

        // Truncated frame: SOF after 5 pixels, then full frame; SOF during drain is missed
        frame_pixels(0, 4, 1'b1);
        exp_err = 1'b1;
        frame_pixels(0, NPIX - 1, 1'b1);
        drain(1'b1, NPIX);
        tick();
        chk("missed_sof_start", 32'(oFrameStart), 0);
        chk("missed_sof_busy", 32'(oBusy), 0);

        // iEnable dropped mid-frame: frame completes, then block idles
        frame_pixels(0, 1, 1'b1);
        iEnable = 1'b0;
        frame_pixels(2, NPIX - 1, 1'b1);
        drain(1'b0, NPIX);
        tick();
        chk("idle_after_drop", 32'(oBusy), 0);
        pix(0, 1'b0);
        chk("idle_no_start", 32'(oFrameStart), 0);

        // Reset mid-RUN: everything cleared, no done pulse, re-arms with synchronizer at 0
        iEnable = 1'b1;
        tick();
        exp_mode = iSwitch;
        frame_pixels(0, 2, 1'b1);
        iRST = 1'b0;
        tick();
        iRST = 1'b1;
        exp_cnt = '0; exp_err = 1'b0; exp_mode = 1'b0;
        chk_all_zero("midrst");
        for (int i = 0; i <= LAT; i++) begin
            tick();
            chk("midrst_no_done", 32'(oFrameDone), 0);
            chk("midrst_mode", 32'(oMode), 0);
        end
        frame_pixels(0, NPIX - 1, 1'b1);
        drain(1'b0, NPIX);

        // Short frame: EOF after 5 pixels sets the sticky error
        frame_pixels(0, 3, 1'b1);
        exp_err = 1'b1;
        pix(NPIX - 1, 1'b1);
        drain(1'b0, 5);

        // Frame counter wraps 0xFFFF -> 0
        force dut.r_frame_cnt = 16'hFFFF;
        #1;
        release dut.r_frame_cnt;
        exp_cnt = 16'hFFFF;
        tick();
        chk("cnt_preload", 32'(oFrameCnt), 32'(exp_cnt));
        frame_pixels(0, NPIX - 1, 1'b1);
        drain(1'b0, NPIX);
        chk("cnt_wrap", 32'(oFrameCnt), 0);

        // Random back-to-back frames with random switch levels
        for (int k = 0; k < 4; k++) begin
            iSwitch = 1'($urandom_range(0, 1));
            frame_pixels(0, NPIX - 1, 1'b1);
            drain(1'b0, NPIX);
            chk("mode_rand", 32'(oMode), 32'(exp_mode));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/image_proc_ctrl.md
Name: image_proc_ctrl

Overview:
Frame-level sequencer in front of the greyscale -> convolution -> abs pipeline. It gates pixel-valid into the pipeline on frame boundaries and freezes the filter-direction mode for a whole frame. After the last pixel of each frame it drains the pipeline latency and reports frame completion. It sits between the CCD capture counters/switch inputs and image_processing.

Parameters:
IMG_W, 640, active pixels per line; the last column is IMG_W-1.
IMG_H, 480, active lines per frame; the last row is IMG_H-1.
PIPE_LAT, 4, cycles from the last gated pixel to the final conv output; must be >= 1.
SYNC_STAGES, 2, flop stages on the asynchronous iSwitch input; must be >= 2.

Ports:
iCLK  in  1  system clock; the only clock.
iRST  in  1  synchronous, active-low reset.
iEnable  in  1  run request; level-sensitive.
iSwitch  in  1  raw filter-direction switch, asynchronous (0 vertical, 1 horizontal).
iX_Cont  in  11  capture column counter.
iY_Cont  in  11  capture row counter.
iDVAL  in  1  capture pixel valid.
oDVAL  out  1  gated pixel valid to the pipeline; combinational.
oMode  out  1  registered per-frame filter direction, same polarity as iSwitch.
oBusy  out  1  high in RUN or DRAIN.
oFrameStart  out  1  one-cycle registered pulse.
oFrameDone  out  1  one-cycle registered pulse.
oFrameCnt  out  16  completed-frame count; wraps 0xFFFF -> 0.
oErr  out  1  sticky frame-size error.

Behaviour:
- Reset: iRST low at a clock edge clears all registers on that edge. State becomes IDLE; all outputs are 0; the synchronizer chain is cleared. Reset mid-frame drops the frame with no oFrameDone.
- SOF: iDVAL && iX_Cont==0 && iY_Cont==0.
- EOF: iDVAL && iX_Cont==IMG_W-1 && iY_Cont==IMG_H-1.
- sw_s: iSwitch after SYNC_STAGES flops.
- IDLE:
  - oDVAL = 0.
  - If iEnable: go to ARMED and load oMode <= sw_s on the same edge.
- ARMED:
  - oDVAL = iDVAL && SOF, so the first pixel passes with zero latency.
  - If !iEnable: go to IDLE.
  - Else on SOF: go to RUN, pulse oFrameStart next cycle, set pix_cnt = 1.
- RUN:
  - oDVAL = iDVAL.
  - pix_cnt (20 bits) increments on each iDVAL.
  - On EOF: go to DRAIN. If pix_cnt+1 != IMG_W*IMG_H, set oErr.
  - SOF in RUN (truncated frame): set oErr, reset pix_cnt to 1, pulse oFrameStart, stay in RUN. oMode is not reloaded.
  - iEnable low in RUN is ignored; the frame completes.
- DRAIN:
  - oDVAL = 0; pixels arriving here are dropped.
  - drain_cnt counts 0..PIPE_LAT-1. On reaching PIPE_LAT-1:
    - pulse oFrameDone next cycle and increment oFrameCnt;
    - if iEnable, go to ARMED and load oMode <= sw_s; else go to IDLE.
  - A SOF during DRAIN is missed; ARMED waits for the next SOF.
- oMode changes only on edges entering ARMED, so it is constant while oBusy is high.
- An EOF pixel together with SOF (degenerate 1x1 image) is treated as EOF.
- oErr clears only on reset.

Optional Feature:
IMG_PROC_CTRL_STATS_EN
- Defined: adds port oLastPixCnt (out, 20 bits). It is loaded with the final pix_cnt (including the EOF pixel) on the edge leaving DRAIN, and reset to 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package image_proc_pkg holds:
  - state enum {IDLE, ARMED, RUN, DRAIN} (2-bit);
  - COORD_W = 11, PIX_CNT_W = 20, FRAME_CNT_W = 16;
  - default IMG_W/IMG_H.
- One sub-module, sync_ff (parameterised depth, reset to 0), instantiated for iSwitch.

Test Plan:
- 4x2 frame (IMG_W=4, IMG_H=2, PIPE_LAT=3), iEnable=1, iSwitch=1 held: oMode=1 before SOF; oDVAL follows iDVAL for 8 pixels; oFrameDone pulses 4 cycles after EOF (3 drain cycles plus the registered pulse); oFrameCnt=1; oErr=0.
- Toggle iSwitch 0 -> 1 mid-frame: oMode stays 0 until DRAIN exits, then becomes 1 for the next frame.
- Truncated frame: SOF after 5 of 8 pixels -> oErr=1, second oFrameStart pulse, then a full frame completes with oFrameCnt=1.
- Drop iEnable during RUN -> frame completes, oFrameDone pulses, state IDLE, next SOF gives oDVAL=0.
- Assert iRST low mid-RUN for 1 cycle -> next cycle all outputs 0, no oFrameDone; with iEnable=1 the block re-arms and the next SOF passes.
- Preload oFrameCnt to 0xFFFF and complete one frame -> oFrameCnt=0.
